// File: rtl/opl2_pkg.sv
// Shared OPL2 constants and types, extended with the multi-bank tremolo LFO
// definitions. Optional feature macro used by the tremolo files:
// TREMOLO_LFO_SYNC_EN.
package opl2_pkg;

    localparam int OP_NUM_WIDTH    = 5;
    localparam int AM_VAL_WIDTH    = 5;

    localparam int TREMOLO_PEAK    = 26;
    localparam int TREMOLO_SHIFT   = 8;
    localparam int TREMOLO_DEPTH_W = 2;

    typedef enum logic [TREMOLO_DEPTH_W-1:0] {
        TREM_SHALLOW = 2'd0,
        TREM_DEEP    = 2'd1,
        TREM_MID     = 2'd2,
        TREM_OFF     = 2'd3
    } tremolo_depth_t;

    // Width of a bank selector; a single bank still gets a 1-bit select.
    function automatic int bank_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tremolo_lfo_multi_if.sv
// Operator-side bus of the multi-bank tremolo LFO: sample strobe, operator
// slot, bank select, per-bank configuration and the AM/wrap results.
// Optional macro TREMOLO_LFO_SYNC_EN adds the per-bank lfo_sync lines.
interface tremolo_lfo_multi_if
    import opl2_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int STEP_W    = 3
);
    localparam int BANK_W = bank_sel_w(NUM_BANKS);

    logic                                sample_clk_en;
    logic [OP_NUM_WIDTH-1:0]             op_num;
    logic [BANK_W-1:0]                   bank_num;
    logic [NUM_BANKS-1:0][1:0]           dam;
    logic [NUM_BANKS-1:0][STEP_W-1:0]    step;
`ifdef TREMOLO_LFO_SYNC_EN
    logic [NUM_BANKS-1:0]                lfo_sync;
`endif
    logic [AM_VAL_WIDTH-1:0]             am_val_p2;
    logic [NUM_BANKS-1:0]                lfo_wrap;

    modport master (
        output sample_clk_en, op_num, bank_num, dam, step,
`ifdef TREMOLO_LFO_SYNC_EN
        output lfo_sync,
`endif
        input  am_val_p2, lfo_wrap
    );

    modport slave (
        input  sample_clk_en, op_num, bank_num, dam, step,
`ifdef TREMOLO_LFO_SYNC_EN
        input  lfo_sync,
`endif
        output am_val_p2, lfo_wrap
    );

endinterface

// File: rtl/tremolo_lfo_bank.sv
// One tremolo LFO bank: index counter with remainder-preserving wrap and a
// symmetric triangle shaper. With TREMOLO_LFO_SYNC_EN defined a sync input
// clears the index and overrides an advance in the same cycle.
module tremolo_lfo_bank
    import opl2_pkg::*;
#(
    parameter int PEAK   = TREMOLO_PEAK,
    parameter int SHIFT  = TREMOLO_SHIFT,
    parameter int STEP_W = 3,
    parameter int IDX_W  = 15,
    parameter int TRI_W  = AM_VAL_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance_i,
    input  logic [STEP_W-1:0] step_i,
`ifdef TREMOLO_LFO_SYNC_EN
    input  logic              sync_i,
`endif
    output logic [TRI_W-1:0]  tri_val_o,
    output logic              wrap_o
);

    localparam logic [IDX_W:0] MAX_COUNT = (IDX_W+1)'((2*PEAK + 2) << SHIFT);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] raw;

    // One extra bit so idx + step can never overflow before the wrap test.
    assign sum = {1'b0, idx_q} + {{(IDX_W+1-STEP_W){1'b0}}, step_i};

    // Next index: advance with remainder-preserving wrap; sync wins.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (advance_i) begin
            if (sum >= MAX_COUNT) begin
                idx_d  = IDX_W'(sum - MAX_COUNT);
                wrap_d = 1'b1;
            end else begin
                idx_d  = sum[IDX_W-1:0];
            end
        end
`ifdef TREMOLO_LFO_SYNC_EN
        if (sync_i) begin
            idx_d  = '0;
            wrap_d = 1'b0;
        end
`endif
    end

    // Index and wrap-pulse state.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    // Triangle: rising 0..PEAK, then mirrored PEAK..0 on the upper half.
    assign raw       = idx_q >> SHIFT;
    assign tri_val_o = (raw <= IDX_W'(PEAK)) ? TRI_W'(raw)
                                             : TRI_W'(IDX_W'(2*PEAK + 1) - raw);
    assign wrap_o    = wrap_q;

endmodule

// File: rtl/tremolo_lfo_multi.sv
// Multi-bank tremolo LFO: NUM_BANKS independent triangle LFOs advanced on
// operator slot 0 of each sample, a bank mux (p1) and a depth map (p2)
// giving the AM offset two clocks after the operator is presented.
// Optional macro TREMOLO_LFO_SYNC_EN enables per-bank index sync.
module tremolo_lfo_multi
    import opl2_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int PEAK      = TREMOLO_PEAK,
    parameter int SHIFT     = TREMOLO_SHIFT,
    parameter int STEP_W    = 3,
    parameter int IDX_W     = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    tremolo_lfo_multi_if.slave    bus
);

    localparam int BANK_W = bank_sel_w(NUM_BANKS);

    logic                                 advance;
    logic [NUM_BANKS-1:0][AM_VAL_WIDTH-1:0] tri_all;
    logic [NUM_BANKS-1:0]                 wrap_all;
    logic [BANK_W-1:0]                    sel_bank;

    logic [AM_VAL_WIDTH-1:0] sel_tri_q, sel_tri_d;
    tremolo_depth_t          sel_dam_q, sel_dam_d;
    logic [AM_VAL_WIDTH-1:0] am_val_q,  am_val_d;

    // All banks advance together once per sample, on operator slot 0.
    assign advance = bus.sample_clk_en && (bus.op_num == '0);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            tremolo_lfo_bank #(
                .PEAK   (PEAK),
                .SHIFT  (SHIFT),
                .STEP_W (STEP_W),
                .IDX_W  (IDX_W),
                .TRI_W  (AM_VAL_WIDTH)
            ) u_bank (
                .clk       (clk),
                .reset     (reset),
                .advance_i (advance),
                .step_i    (bus.step[gi]),
`ifdef TREMOLO_LFO_SYNC_EN
                .sync_i    (bus.lfo_sync[gi]),
`endif
                .tri_val_o (tri_all[gi]),
                .wrap_o    (wrap_all[gi])
            );
        end
    endgenerate

    // Out-of-range bank numbers fall back to bank 0.
    always_comb begin
        sel_bank = bus.bank_num;
        if ({1'b0, bus.bank_num} >= (BANK_W+1)'(NUM_BANKS))
            sel_bank = '0;
    end

    // p1 next state: triangle and depth mode of the selected bank.
    always_comb begin
        sel_tri_d = tri_all[sel_bank];
        sel_dam_d = tremolo_depth_t'(bus.dam[sel_bank]);
    end

    // p2 next state: depth map applied to the selected triangle.
    always_comb begin
        am_val_d = '0;
        case (sel_dam_q)
            TREM_SHALLOW: am_val_d = sel_tri_q >> 2;
            TREM_DEEP:    am_val_d = sel_tri_q;
            TREM_MID:     am_val_d = sel_tri_q >> 1;
            TREM_OFF:     am_val_d = '0;
            default:      am_val_d = '0;
        endcase
    end

    // Two-stage output pipeline, running every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_tri_q <= '0;
            sel_dam_q <= TREM_SHALLOW;
            am_val_q  <= '0;
        end else begin
            sel_tri_q <= sel_tri_d;
            sel_dam_q <= sel_dam_d;
            am_val_q  <= am_val_d;
        end
    end

    assign bus.am_val_p2 = am_val_q;
    assign bus.lfo_wrap  = wrap_all;

endmodule

// File: tb/tb_tremolo_lfo_multi.sv
// Bench for tremolo_lfo_multi: a plain-arithmetic model of each bank index
// and of the 2-cycle AM output, compared every cycle, plus hand-computed
// checkpoints and a randomized phase.
module tb_tremolo_lfo_multi;
    import opl2_pkg::*;

    localparam int NB     = 2;
    localparam int STEP_W = 3;
    localparam int PEAK   = 26;
    localparam int SHIFT  = 8;
    localparam int MAXC   = (2*PEAK + 2) << SHIFT;   // 13824

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tremolo_lfo_multi_if #(.NUM_BANKS(NB), .STEP_W(STEP_W)) bus ();

    tremolo_lfo_multi #(
        .NUM_BANKS (NB),
        .PEAK      (PEAK),
        .SHIFT     (SHIFT),
        .STEP_W    (STEP_W),
        .IDX_W     (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests  = 0;
    int fails  = 0;
    int m_idx [NB];
    int e1 = 0;
    int e2 = 0;
    logic [NB-1:0] ew = '0;
    bit chk_en = 1'b0;
    int n26    = 0;
    int nwrap0 = 0;

    function automatic int exp_am(input int idx, input int d);
        int seg;
        int t;
        seg = idx / (1 << SHIFT);
        t   = (seg <= PEAK) ? seg : (2*PEAK + 1 - seg);
        case (d)
            0:       return t / 4;
            1:       return t;
            2:       return t / 2;
            default: return 0;
        endcase
    endfunction

    function automatic int sel_bank();
        int b;
        b = int'(bus.bank_num);
        return (b < NB) ? b : 0;
    endfunction

    function automatic bit sync_on(input int b);
`ifdef TREMOLO_LFO_SYNC_EN
        return bus.lfo_sync[b];
`else
        return (b < 0);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: indices as plain integers modulo MAX, outputs delayed 2 cycles.
    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) m_idx[b] <= 0;
            e1 <= 0;
            e2 <= 0;
            ew <= '0;
        end else begin
            e2 <= e1;
            e1 <= exp_am(m_idx[sel_bank()], int'(bus.dam[sel_bank()]));
            for (int b = 0; b < NB; b++) begin
                if (sync_on(b)) begin
                    m_idx[b] <= 0;
                    ew[b]    <= 1'b0;
                end else if (bus.sample_clk_en && bus.op_num == 0) begin
                    m_idx[b] <= (m_idx[b] + int'(bus.step[b])) % MAXC;
                    ew[b]    <= (m_idx[b] + int'(bus.step[b])) >= MAXC;
                end else begin
                    ew[b]    <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (bus.am_val_p2 !== AM_VAL_WIDTH'(e2)) begin
                fails++;
                $display("FAIL am_val_p2 @%0t: got %0d expected %0d", $time, bus.am_val_p2, e2);
            end
            tests++;
            if (bus.lfo_wrap !== ew) begin
                fails++;
                $display("FAIL lfo_wrap @%0t: got %b expected %b", $time, bus.lfo_wrap, ew);
            end
            if (bus.am_val_p2 == AM_VAL_WIDTH'(26)) n26++;
            if (bus.lfo_wrap[0]) nwrap0++;
        end
    end

    task automatic run_adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sample_clk_en = 1'b1;
            bus.op_num        = '0;
        end
        @(negedge clk);
        bus.sample_clk_en = 1'b0;
        bus.op_num        = OP_NUM_WIDTH'(1);
    endtask

    task automatic probe(input string name, input int bank, input logic [1:0] d, input int exp);
        @(negedge clk);
        bus.sample_clk_en = 1'b0;
        bus.op_num        = OP_NUM_WIDTH'(7);
        bus.bank_num      = 1'(bank);
        bus.dam[bank]     = d;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check(name, int'(bus.am_val_p2), exp);
        $display("[TB] probe %s bank=%0d dam=%0d am_val_p2=%0d", name, bank, d, bus.am_val_p2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int s26;
    int sw;

    initial begin
        bus.sample_clk_en = 1'b0;
        bus.op_num        = '0;
        bus.bank_num      = '0;
        bus.dam           = '0;
        bus.step          = '0;
`ifdef TREMOLO_LFO_SYNC_EN
        bus.lfo_sync      = '0;
`endif
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_am", int'(bus.am_val_p2), 0);
        check("reset_wrap", int'(bus.lfo_wrap), 0);
        reset = 1'b0;

        // 256 advances at step 1: triangle reaches 1.
        bus.step = {3'd1, 3'd1};
        bus.dam  = {2'b01, 2'b01};
        run_adv(256);
        probe("idx256_deep", 0, 2'b01, 1);

        // Complete the period: one wrap, apex held for 512 samples.
        s26 = n26;
        sw  = nwrap0;
        run_adv(MAXC - 256);
        probe("wrap_idx0", 0, 2'b01, 0);
        check("wrap_pulses", nwrap0 - sw, 1);
        check("peak_hold", n26 - s26, 512);

        // Independent rates: bank 1 at step 4 reaches the apex first.
        do_reset();
        bus.step = {3'd4, 3'd1};
        bus.dam  = {2'b00, 2'b01};
        run_adv(1728);
        probe("b1_peak_shallow", 1, 2'b00, 6);
        probe("b0_deep", 0, 2'b01, 6);

        // Remainder-preserving wrap from MAX-2 with step 5 -> 3.
        do_reset();
        bus.step = {3'd1, 3'd2};
        run_adv((MAXC - 2) / 2);
        bus.step[0] = 3'd5;
        sw = nwrap0;
        run_adv(1);
        @(negedge clk);
        check("rem_wrap_pulse", nwrap0 - sw, 1);
        bus.step[0] = 3'd1;
        run_adv(252);
        probe("rem_255", 0, 2'b01, 0);
        run_adv(1);
        probe("rem_256", 0, 2'b01, 1);

        // Depth modes at the apex; non-zero op strobe does not advance.
        do_reset();
        bus.step = {3'd3, 3'd1};
        run_adv(6655);
        probe("pre_peak", 0, 2'b01, 25);
        @(negedge clk);
        bus.sample_clk_en = 1'b1;
        bus.op_num        = OP_NUM_WIDTH'(3);
        @(negedge clk);
        bus.sample_clk_en = 1'b0;
        probe("op_nonzero_no_adv", 0, 2'b01, 25);
        run_adv(1);
        probe("peak_dam11", 0, 2'b11, 0);
        probe("peak_dam10", 0, 2'b10, 13);
        probe("peak_dam01", 0, 2'b01, 26);
        probe("peak_dam00", 0, 2'b00, 6);

        // Reset in the middle of a period clears the output next cycle.
        @(negedge clk);
        bus.dam[0] = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_am", int'(bus.am_val_p2), 26);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_am", int'(bus.am_val_p2), 0);
        check("reset_mid_wrap", int'(bus.lfo_wrap), 0);
        reset = 1'b0;

`ifdef TREMOLO_LFO_SYNC_EN
        // Sync overrides a simultaneous advance.
        bus.step = {3'd1, 3'd1};
        run_adv(300);
        @(negedge clk);
        bus.lfo_sync[0]   = 1'b1;
        bus.sample_clk_en = 1'b1;
        bus.op_num        = '0;
        @(negedge clk);
        bus.lfo_sync      = '0;
        bus.sample_clk_en = 1'b0;
        bus.op_num        = OP_NUM_WIDTH'(1);
        probe("sync_idx0", 0, 2'b01, 0);
        probe("sync_other_bank", 1, 2'b01, 1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            reset             = ($urandom_range(0, 2999) == 0);
            bus.sample_clk_en = ($urandom_range(0, 7) != 0);
            bus.op_num        = ($urandom_range(0, 3) != 0) ? OP_NUM_WIDTH'(0)
                                                            : OP_NUM_WIDTH'($urandom_range(1, 17));
            bus.bank_num      = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.dam = (2*NB)'($urandom);
            if (i % 700 == 0) bus.step = (STEP_W*NB)'($urandom);
`ifdef TREMOLO_LFO_SYNC_EN
            bus.lfo_sync      = ($urandom_range(0, 499) == 0) ? NB'($urandom) : '0;
`endif
        end
        @(negedge clk);
        reset = 1'b0;
        bus.sample_clk_en = 1'b0;
`ifdef TREMOLO_LFO_SYNC_EN
        bus.lfo_sync = '0;
`endif
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
